// File: rtl/raster_pixel_traversal_if.sv
// Triangle/pixel record types and the handshake bundle between triangle setup,
// the raster traversal block and pixel evaluation.
package raster_pkg;
  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] bbox_min_x;
    logic [15:0] bbox_max_x;
    logic [15:0] bbox_min_y;
    logic [15:0] bbox_max_y;
    logic [15:0] denom_inv;   // Q0.16
  } triangle_state_t;

  typedef struct packed {
    logic [15:0]     x;
    logic [15:0]     y;
    triangle_state_t triangle;
  } pixel_state_t;
endpackage

interface raster_pixel_traversal_if;
  import raster_pkg::*;
  triangle_state_t tri_in;
  logic            tri_in_valid;
  logic            tri_in_ready;
  pixel_state_t    pixel_out;
  logic            pixel_out_valid;
  logic            pixel_out_ready;

  modport slave  (input  tri_in, tri_in_valid, pixel_out_ready,
                  output tri_in_ready, pixel_out, pixel_out_valid);
  modport master (output tri_in, tri_in_valid, pixel_out_ready,
                  input  tri_in_ready, pixel_out, pixel_out_valid);
endinterface

// File: rtl/raster_pixel_traversal.sv
// Walks the screen-clipped bbox of each triangle in raster order, one pixel per
// cycle, with a single registered output stage.
module raster_pixel_traversal
  import raster_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 240
) (
    input  logic clk,
    input  logic rst_n,
    raster_pixel_traversal_if.slave bus,
    output logic tri_done,
    output logic busy
);
    localparam logic [15:0] XMAX = 16'(SCREEN_WIDTH - 1);
    localparam logic [15:0] YMAX = 16'(SCREEN_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, CLIP, SCAN} state_t;
    state_t state, state_n;

    triangle_state_t tri_reg;
    pixel_state_t    pix_q;
    logic [15:0]     cmax_x, cmax_y, cur_x, cur_y;
    logic [15:0]     clip_x, clip_y;
    logic            vld_q, last_q, empty_pend;
    logic            advance, at_last, empty, empty_evt, last_hs;

    assign clip_x    = (tri_reg.bbox_max_x > XMAX) ? XMAX : tri_reg.bbox_max_x;
    assign clip_y    = (tri_reg.bbox_max_y > YMAX) ? YMAX : tri_reg.bbox_max_y;
    assign empty     = (tri_reg.bbox_min_x > clip_x) || (tri_reg.bbox_min_y > clip_y);
    assign advance   = !vld_q || bus.pixel_out_ready;
    assign at_last   = (cur_x == cmax_x) && (cur_y == cmax_y);
    assign empty_evt = (state == CLIP) && empty;
    assign last_hs   = vld_q && bus.pixel_out_ready && last_q;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.tri_in_valid) state_n = CLIP;
            CLIP:    state_n = empty ? IDLE : SCAN;
            SCAN:    if (advance && at_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tri_reg <= '0;
            cmax_x  <= '0;
            cmax_y  <= '0;
            cur_x   <= '0;
            cur_y   <= '0;
        end else begin
            if (state == IDLE && bus.tri_in_valid) tri_reg <= bus.tri_in;
            if (state == CLIP) begin
                cmax_x <= clip_x;
                cmax_y <= clip_y;
                cur_x  <= tri_reg.bbox_min_x;
                cur_y  <= tri_reg.bbox_min_y;
            end
            if (state == SCAN && advance) begin
                if (cur_x == cmax_x) begin
                    cur_x <= tri_reg.bbox_min_x;
                    cur_y <= cur_y + 16'd1;
                end else begin
                    cur_x <= cur_x + 16'd1;
                end
            end
        end
    end

    // Output stage; last_q rides along so tri_done follows the real handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q  <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else if (advance) begin
            if (state == SCAN) begin
                pix_q  <= '{x: cur_x, y: cur_y, triangle: tri_reg};
                vld_q  <= 1'b1;
                last_q <= at_last;
            end else begin
                vld_q  <= 1'b0;
                last_q <= 1'b0;
            end
        end
    end

    // A last-pixel handoff wins the pulse; an empty-triangle pulse waits a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tri_done   <= 1'b0;
            empty_pend <= 1'b0;
        end else begin
            tri_done   <= last_hs || empty_evt || empty_pend;
            empty_pend <= last_hs && (empty_evt || empty_pend);
        end
    end

    assign bus.tri_in_ready    = (state == IDLE);
    assign bus.pixel_out       = pix_q;
    assign bus.pixel_out_valid = vld_q;
    assign busy                = (state != IDLE) || vld_q;
endmodule

// File: tb/tb_raster_pixel_traversal.sv
// Directed bench for raster_pixel_traversal: scoreboard of expected raster pixels
// built from clipped bbox loops, plus literal timing/value checks.
module tb_raster_pixel_traversal;
  import raster_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic tri_done, busy;
  raster_pixel_traversal_if bus();

  raster_pixel_traversal #(.SCREEN_WIDTH(320), .SCREEN_HEIGHT(240)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .tri_done(tri_done), .busy(busy));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int done_seen = 0, exp_done = 0;
  int ready_mode = 0, rcnt = 0;
  pixel_state_t exp_q[$];
  pixel_state_t held;
  logic stall_chk = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic triangle_state_t mk(input logic [7:0] id, input int x0, x1, y0, y1);
    triangle_state_t t;
    t.id = id;
    t.bbox_min_x = 16'(x0); t.bbox_max_x = 16'(x1);
    t.bbox_min_y = 16'(y0); t.bbox_max_y = 16'(y1);
    t.denom_inv = 16'h1234 + 16'(id);
    return t;
  endfunction

  // Model: every on-screen pixel of the bbox, row by row.
  task automatic model_tri(input triangle_state_t t);
    int xe, ye;
    xe = (int'(t.bbox_max_x) > 319) ? 319 : int'(t.bbox_max_x);
    ye = (int'(t.bbox_max_y) > 239) ? 239 : int'(t.bbox_max_y);
    for (int y = int'(t.bbox_min_y); y <= ye; y++)
      for (int x = int'(t.bbox_min_x); x <= xe; x++)
        exp_q.push_back('{x: 16'(x), y: 16'(y), triangle: t});
    exp_done++;
  endtask

  task automatic send_tri(input triangle_state_t t, output logic vld_at_accept);
    logic rdy;
    int n = 0;
    @(posedge clk); #1;
    bus.tri_in = t;
    bus.tri_in_valid = 1'b1;
    vld_at_accept = 1'b0;
    forever begin
      @(negedge clk);
      rdy = bus.tri_in_ready;
      vld_at_accept = bus.pixel_out_valid;
      @(posedge clk);
      if (rdy) break;
      if (++n > 200) begin
        chk("tri_accept_timeout", 0, 1);
        break;
      end
    end
    #1 bus.tri_in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_seen < exp_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("done_wait", 64'(done_seen), 64'(exp_done));
  endtask

  initial forever begin
    @(posedge clk); #1;
    rcnt++;
    case (ready_mode)
      0:       bus.pixel_out_ready = 1'b1;
      1:       bus.pixel_out_ready = (rcnt % 3 == 0);
      default: bus.pixel_out_ready = 1'b0;
    endcase
  end

  // Scoreboard compare: every handoff pops the model; stalled output must hold.
  always @(negedge clk) begin
    if (stall_chk && bus.pixel_out_valid)
      chk("stall_hold", 64'(bus.pixel_out.x == held.x && bus.pixel_out.y == held.y &&
                             bus.pixel_out.triangle == held.triangle), 1);
    stall_chk = 1'b0;
    if (rst_n && bus.pixel_out_valid) begin
      if (bus.pixel_out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_pixel", {bus.pixel_out.x, bus.pixel_out.y}, 0);
        else begin
          pixel_state_t e;
          e = exp_q.pop_front();
          chk("pixel_xy_id", {bus.pixel_out.triangle.id, bus.pixel_out.x, bus.pixel_out.y},
              {e.triangle.id, e.x, e.y});
        end
      end else begin
        held = bus.pixel_out;
        stall_chk = 1'b1;
      end
    end
    if (tri_done) done_seen++;
  end

  initial begin
    triangle_state_t t;
    logic va;
    rst_n = 1'b0;
    bus.tri_in = '0;
    bus.tri_in_valid = 1'b0;
    bus.pixel_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(bus.pixel_out_valid), 0);
    chk("rst_done", 64'(tri_done), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_ready", 64'(bus.tri_in_ready), 1);

    // Test 1: 2x2 box, ready high, exact cycle timing
    t = mk(8'd1, 10, 11, 5, 6);
    model_tri(t);
    send_tri(t, va);
    @(negedge clk); chk("t1_n0_valid", 64'(bus.pixel_out_valid), 0); chk("t1_n0_busy", 64'(busy), 1);
    @(negedge clk); chk("t1_n1_valid", 64'(bus.pixel_out_valid), 0);
    @(negedge clk); chk("t1_p0", {15'd0, bus.pixel_out_valid, bus.pixel_out.x, bus.pixel_out.y}, {15'd0, 1'b1, 16'd10, 16'd5});
    @(negedge clk); chk("t1_p1", {bus.pixel_out.x, bus.pixel_out.y}, {16'd11, 16'd5});
    @(negedge clk); chk("t1_p2", {bus.pixel_out.x, bus.pixel_out.y}, {16'd10, 16'd6});
    @(negedge clk); chk("t1_p3", {bus.pixel_out.x, bus.pixel_out.y}, {16'd11, 16'd6});
    chk("t1_done_early", 64'(tri_done), 0);
    @(negedge clk); chk("t1_done", 64'(tri_done), 1); chk("t1_valid_off", 64'(bus.pixel_out_valid), 0);
    @(negedge clk); chk("t1_done_pulse", 64'(tri_done), 0);

    // Test 2: same box, ready toggling 1,0,0
    ready_mode = 1;
    t = mk(8'd2, 10, 11, 5, 6);
    model_tri(t);
    send_tri(t, va);
    wait_done(200);
    ready_mode = 0;

    // Test 3: box straddling the bottom-right screen corner
    t = mk(8'd3, 318, 325, 238, 250);
    model_tri(t);
    chk("t3_model_count", 64'(exp_q.size()), 4);
    send_tri(t, va);
    wait_done(100);

    // Test 4: fully offscreen box
    t = mk(8'd4, 400, 410, 0, 5);
    model_tri(t);
    chk("t4_model_count", 64'(exp_q.size()), 0);
    send_tri(t, va);
    @(negedge clk); chk("t4_n0_done", 64'(tri_done), 0);
    @(negedge clk); chk("t4_n1_done", 64'(tri_done), 1); chk("t4_ready", 64'(bus.tri_in_ready), 1);
    chk("t4_valid", 64'(bus.pixel_out_valid), 0);
    @(negedge clk); chk("t4_n2_done", 64'(tri_done), 0);
    done_seen = exp_done;

    // Test 5: single pixel stalled while the next triangle is accepted
    ready_mode = 2;
    t = mk(8'd5, 7, 7, 7, 7);
    model_tri(t);
    send_tri(t, va);
    t = mk(8'd6, 0, 1, 0, 0);
    model_tri(t);
    send_tri(t, va);
    chk("t5_accept_during_stall", 64'(va), 1);
    @(negedge clk);
    chk("t5_held", {15'd0, bus.pixel_out_valid, bus.pixel_out.x, bus.pixel_out.y}, {15'd0, 1'b1, 16'd7, 16'd7});
    @(posedge clk); #2 ready_mode = 0;
    wait_done(100);

    // Test 6: reset in the middle of a 4x4 scan
    t = mk(8'd7, 0, 3, 0, 3);
    model_tri(t);
    send_tri(t, va);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("t6_async_valid", 64'(bus.pixel_out_valid), 0);
    chk("t6_async_busy", 64'(busy), 0);
    exp_q.delete();
    exp_done--;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_busy", 64'(busy), 0);
    chk("t6_ready", 64'(bus.tri_in_ready), 1);
    chk("t6_valid", 64'(bus.pixel_out_valid), 0);
    repeat (10) @(negedge clk);

    chk("final_queue_empty", 64'(exp_q.size()), 0);
    chk("final_done_count", 64'(done_seen), 64'(exp_done));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
